pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined add/subtract unit built from carry-lookahead groups.
- Operand width is split into STAGES = WIDTH/BLOCK slices. Each pipeline stage resolves one BLOCK-bit slice with 4-bit lookahead groups and registers the slice carry for the next stage.
- Valid/ready handshake on both sides with full backpressure, for use on datapaths where a single-cycle WIDTH-bit adder misses timing.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of BLOCK.
BLOCK, 8, bits resolved per pipeline stage; must be a multiple of 4 and ≥4.
(derived) STAGES = WIDTH/BLOCK, pipeline depth and latency in cycles.

Ports:
Clk_i  input  1  clock, all state updates on rising edge
Reset_ni  input  1  synchronous active-low reset
Valid_i  input  1  input operands valid
Ready_o  output  1  unit can accept an operation this cycle
Number1_i  input  WIDTH  operand A
Number2_i  input  WIDTH  operand B
Carry_i  input  1  carry-in (add mode only)
Sub_i  input  1  0 = A+B+Carry_i, 1 = A−B
Valid_o  output  1  result valid
Ready_i  input  1  downstream accepts result
Result_o  output  WIDTH  sum/difference
Carry_o  output  1  carry-out of MSB; in Sub mode 1 = no borrow
Overflow_o  output  1  signed two's-complement overflow

Behaviour:
- Clock and reset: one clock, Clk_i. Reset_ni is synchronous and active-low. It is sampled only on the rising edge of Clk_i.
- Reset values: Valid_o=0, Result_o=0, Carry_o=0, Overflow_o=0. All per-stage valid bits, partial results and carries are cleared.
- Reset mid-operation: every in-flight operation is discarded with no output. Ready_o=1 in the first cycle after reset deasserts.
- Global advance enable: en = !Valid_o || Ready_i.
  - Ready_o = en, combinational, with no dependency on Valid_i.
  - When en=1, every stage register shifts forward one stage.
  - When en=0, all stages hold: data, carries and valid bits are unchanged.
- Bubbles are not collapsed. Stage valid bits shift with the data.
- Input transfer: occurs when Valid_i && Ready_o. A cycle with Valid_i=0 and en=1 inserts a bubble (stage-0 valid=0).
- Output transfer: occurs when Valid_o && Ready_i.
  - Result_o, Carry_o and Overflow_o are stable while Valid_o=1 and Ready_i=0.
  - Their values are don't-care when Valid_o=0.
- Latency: an operation accepted at edge N is presented with Valid_o=1 after edge N+STAGES−1 completes. Its output registers load at edge N+STAGES−1, so the result is visible in cycle N+STAGES−1..N+STAGES. Precisely, the result is visible STAGES rising edges after acceptance, counting the acceptance edge as edge 1.
- Throughput: one operation per cycle with Ready_i held high.
- Operand preprocessing at stage 0:
  - B' = Sub_i ? ~Number2_i : Number2_i.
  - cin = Sub_i ? 1 : Carry_i.
  - In Sub mode Carry_i is ignored.
  - A, B' and Sub_i are captured at acceptance. Later input changes do not affect in-flight operations.
- Per-stage slice k (bits k·BLOCK..k·BLOCK+BLOCK−1):
  - P = A^B', G = A&B'.
  - 4-bit group lookahead: c[i+1] = G[i] | P[i]&c[i], expanded per group.
  - Group carries ripple between groups inside the slice.
  - Slice sum bits are registered. Unresolved higher operand bits travel alongside.
- Carry_o: carry out of bit WIDTH−1.
- Overflow_o: carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
- Result arithmetic: Result_o = (A + B' + cin) mod 2^WIDTH.
- Boundary conditions:
  - Wrap-around (all-ones + 1) yields 0 with Carry_o=1.
  - Simultaneous accept and emit in the same cycle is legal and loses nothing.
  - STAGES=1 degenerates to a single registered stage with latency 1.

Test Plan (WIDTH=32, BLOCK=8, STAGES=4):
- Basic add: A=0x0000_0005, B=0x0000_0003, Carry_i=1, Sub_i=0 → 4 cycles later Result_o=0x0000_0009, Carry_o=0, Overflow_o=0.
- Full carry chain: A=0xFFFF_FFFF, B=0x0000_0000, Carry_i=1 → Result_o=0x0000_0000, Carry_o=1, Overflow_o=0. Repeat with A=0x7FFF_FFFF, B=1, Carry_i=0 → Result_o=0x8000_0000, Overflow_o=1.
- Subtract: A=0x0000_0003, B=0x0000_0005, Sub_i=1, Carry_i=1 (ignored) → Result_o=0xFFFF_FFFE, Carry_o=0 (borrow). A=0x8000_0000, B=1 → Result_o=0x7FFF_FFFF, Overflow_o=1.
- Streaming with backpressure: issue 8 back-to-back ops A=i, B=i·0x0101_0101 with Ready_i=1. Then hold Ready_i=0 for 3 cycles mid-stream → Ready_o=0 while Valid_o=1; outputs held stable; all 8 results emerge in order with none lost or duplicated.
- Bubbles: alternate Valid_i 1/0 for 6 cycles → Valid_o shows the same 1/0 pattern delayed 4 cycles, and no bubble is collapsed.
- Reset mid-operation: accept 3 ops, assert Reset_ni=0 for one edge → Valid_o=0, Result_o=0, Carry_o=0 next cycle. No stale result appears afterwards. Ready_o=1 after release.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder
//
// Pipelined add/subtract unit. The operands are split into STAGES = WIDTH/BLOCK
// slices. Pipeline stage k resolves bits k*BLOCK .. k*BLOCK+BLOCK-1 using 4-bit
// carry-lookahead groups, with the group carries rippling inside the slice. The
// slice carry-out is registered and feeds stage k+1. The operand bits that are
// not yet resolved travel down the pipe beside the partial sum.
//
// The last stage register is the output register, so an operation accepted on
// one rising edge is presented STAGES edges later, counting the acceptance edge.
//
// Ports
//   Clk_i       clock; all state updates on the rising edge
//   Reset_ni    synchronous active-low reset
//   Valid_i     input operands valid
//   Ready_o     unit can accept an operation this cycle (combinational)
//   Number1_i   operand A
//   Number2_i   operand B
//   Carry_i     carry-in, add mode only
//   Sub_i       0: A + B + Carry_i, 1: A - B
//   Valid_o     result valid
//   Ready_i     downstream accepts the result
//   Result_o    sum / difference
//   Carry_o     carry out of the MSB (in subtract mode 1 means no borrow)
//   Overflow_o  signed two's-complement overflow
// -----------------------------------------------------------------------------
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             Clk_i,
    input  logic             Reset_ni,
    input  logic             Valid_i,
    output logic             Ready_o,
    input  logic [WIDTH-1:0] Number1_i,
    input  logic [WIDTH-1:0] Number2_i,
    input  logic             Carry_i,
    input  logic             Sub_i,
    output logic             Valid_o,
    input  logic             Ready_i,
    output logic [WIDTH-1:0] Result_o,
    output logic             Carry_o,
    output logic             Overflow_o
);

    localparam int STAGES = WIDTH / BLOCK;
    localparam int GROUPS = BLOCK / 4;

    // -------------------------------------------------------------------------
    // Lookahead helpers
    // -------------------------------------------------------------------------

    // Fully expanded 4-bit lookahead: returns carries into bits 1..4 of the
    // group (index 3 is the group carry-out).
    function automatic logic [3:0] cla4_carries(
        input logic [3:0] p,
        input logic [3:0] g,
        input logic       c0
    );
        logic [3:0] c;
        c[0] = g[0]
             | (p[0] & c0);
        c[1] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & c0);
        c[2] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[3] = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    // Adds one BLOCK-bit slice. Result layout:
    //   [BLOCK+1]   carry into the slice MSB (needed for signed overflow)
    //   [BLOCK]     slice carry-out
    //   [BLOCK-1:0] slice sum
    function automatic logic [BLOCK+1:0] slice_add(
        input logic [BLOCK-1:0] a,
        input logic [BLOCK-1:0] b,
        input logic             cin
    );
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] g;
        logic [BLOCK:0]   c;
        logic [3:0]       grp_c;
        p    = a ^ b;
        g    = a & b;
        c    = {(BLOCK + 1){1'b0}};
        c[0] = cin;
        // Each group looks ahead internally; group carries ripple upward.
        for (int grp = 0; grp < GROUPS; grp++) begin
            grp_c              = cla4_carries(p[grp*4 +: 4], g[grp*4 +: 4], c[grp*4]);
            c[grp*4 + 1 +: 4]  = grp_c;
        end
        return {c[BLOCK-1], c[BLOCK], p ^ c[BLOCK-1:0]};
    endfunction

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    logic                en_s;
    logic [WIDTH-1:0]    opnd_b_s;
    logic                cin_s;

    // Stage inputs (what stage k sees this cycle)
    logic [WIDTH-1:0]    src_a_s   [STAGES];
    logic [WIDTH-1:0]    src_b_s   [STAGES];
    logic [WIDTH-1:0]    src_sum_s [STAGES];
    logic [STAGES-1:0]   src_c_s;
    logic [STAGES-1:0]   src_v_s;

    // Stage next-state values
    logic [BLOCK+1:0]    res_s     [STAGES];
    logic [WIDTH-1:0]    opa_s     [STAGES];
    logic [WIDTH-1:0]    opb_s     [STAGES];
    logic [WIDTH-1:0]    sum_s     [STAGES];
    logic [STAGES-1:0]   carry_s;
    logic [STAGES-1:0]   valid_s;
    logic                ovf_s;

    // Stage registers
    logic [WIDTH-1:0]    opa_r     [STAGES];
    logic [WIDTH-1:0]    opb_r     [STAGES];
    logic [WIDTH-1:0]    sum_r     [STAGES];
    logic [STAGES-1:0]   carry_r;
    logic [STAGES-1:0]   valid_r;
    logic                ovf_r;

    // -------------------------------------------------------------------------
    // Handshake: the whole pipe advances together unless a held result blocks it
    // -------------------------------------------------------------------------
    assign en_s    = (~valid_r[STAGES-1]) | Ready_i;
    assign Ready_o = en_s;

    // Operand preprocessing: subtract is A + ~B + 1, and Carry_i is ignored.
    always_comb begin
        if (Sub_i) begin
            opnd_b_s = ~Number2_i;
            cin_s    = 1'b1;
        end else begin
            opnd_b_s = Number2_i;
            cin_s    = Carry_i;
        end
    end

    // Route stage inputs: stage 0 from the ports, stage k from stage k-1.
    always_comb begin
        src_a_s[0]   = Number1_i;
        src_b_s[0]   = opnd_b_s;
        src_sum_s[0] = {WIDTH{1'b0}};
        src_c_s      = {STAGES{1'b0}};
        src_v_s      = {STAGES{1'b0}};
        src_c_s[0]   = cin_s;
        src_v_s[0]   = Valid_i;
        for (int k = 1; k < STAGES; k++) begin
            src_a_s[k]   = opa_r[k-1];
            src_b_s[k]   = opb_r[k-1];
            src_sum_s[k] = sum_r[k-1];
            src_c_s[k]   = carry_r[k-1];
            src_v_s[k]   = valid_r[k-1];
        end
    end

    // Per-stage slice evaluation. Operands shift right so the slice to resolve
    // is always at the bottom; the partial sum shifts right and the new slice
    // enters at the top, so after STAGES stages every slice sits in place.
    always_comb begin
        carry_s = {STAGES{1'b0}};
        valid_s = {STAGES{1'b0}};
        for (int k = 0; k < STAGES; k++) begin
            res_s[k]                  = slice_add(src_a_s[k][BLOCK-1:0],
                                                  src_b_s[k][BLOCK-1:0],
                                                  src_c_s[k]);
            opa_s[k]                  = src_a_s[k] >> BLOCK;
            opb_s[k]                  = src_b_s[k] >> BLOCK;
            sum_s[k]                  = src_sum_s[k] >> BLOCK;
            sum_s[k][WIDTH-1 -: BLOCK] = res_s[k][BLOCK-1:0];
            carry_s[k]                = res_s[k][BLOCK];
            valid_s[k]                = src_v_s[k];
        end
        // Signed overflow: carry into the MSB differs from the carry out of it.
        ovf_s = res_s[STAGES-1][BLOCK+1] ^ res_s[STAGES-1][BLOCK];
    end

    // Pipeline registers: cleared by reset, shift together when enabled, hold otherwise.
    always_ff @(posedge Clk_i) begin
        if (!Reset_ni) begin
            valid_r <= {STAGES{1'b0}};
            carry_r <= {STAGES{1'b0}};
            ovf_r   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                opa_r[k] <= {WIDTH{1'b0}};
                opb_r[k] <= {WIDTH{1'b0}};
                sum_r[k] <= {WIDTH{1'b0}};
            end
        end else if (en_s) begin
            valid_r <= valid_s;
            carry_r <= carry_s;
            ovf_r   <= ovf_s;
            for (int k = 0; k < STAGES; k++) begin
                opa_r[k] <= opa_s[k];
                opb_r[k] <= opb_s[k];
                sum_r[k] <= sum_s[k];
            end
        end
    end

    // The last stage register is the output register.
    assign Valid_o    = valid_r[STAGES-1];
    assign Result_o   = sum_r[STAGES-1];
    assign Carry_o    = carry_r[STAGES-1];
    assign Overflow_o = ovf_r;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_cla_adder
//
// Self-checking bench for pipelined_cla_adder (WIDTH=32, BLOCK=8, STAGES=4).
// Directed vectors from a table, hand-written streaming / bubble / reset
// sequences, and randomized traffic scored against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_pipelined_cla_adder;

    localparam int WIDTH  = 32;
    localparam int BLOCK  = 8;
    localparam int STAGES = WIDTH / BLOCK;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] num1;
    logic [31:0] num2;
    logic        carry_in;
    logic        sub_in;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] result;
    logic        carry_out;
    logic        ovf_out;

    int          checks  = 0;
    int          errors  = 0;
    int          emitted = 0;
    logic [33:0] exp_q [$];
    logic        hold_prev = 1'b0;
    logic [33:0] held = 34'd0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] res;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
        .Clk_i      (clk),
        .Reset_ni   (rst_n),
        .Valid_i    (valid_in),
        .Ready_o    (ready_out),
        .Number1_i  (num1),
        .Number2_i  (num2),
        .Carry_i    (carry_in),
        .Sub_i      (sub_in),
        .Valid_o    (valid_out),
        .Ready_i    (ready_in),
        .Result_o   (result),
        .Carry_o    (carry_out),
        .Overflow_o (ovf_out)
    );

    // Reference: {overflow, carry_out, result} from plain arithmetic.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [31:0] bb;
        logic        c;
        logic [32:0] full;
        logic        ovf;
        bb   = sub ? ~b : b;
        c    = sub ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, bb} + {32'd0, c};
        ovf  = (a[31] == bb[31]) && (full[31] != a[31]);
        return {ovf, full};
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: sampled on the falling edge, predicting transfers
    // that happen on the following rising edge.
    always @(negedge clk) begin
        logic [33:0] e;
        if (!rst_n) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            chk("ready_rule", 32'(ready_out), 32'(!valid_out || ready_in));
            if (hold_prev) begin
                chk("hold_valid", 32'(valid_out), 32'd1);
                chk("hold_result", result, held[31:0]);
                chk("hold_flags", {30'd0, ovf_out, carry_out}, {30'd0, held[33:32]});
            end
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'(valid_out), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_result", result, e[31:0]);
                    chk("sb_carry", 32'(carry_out), 32'(e[32]));
                    chk("sb_overflow", 32'(ovf_out), 32'(e[33]));
                    emitted++;
                end
            end
            if (valid_in && ready_out) begin
                exp_q.push_back(model(num1, num2, carry_in, sub_in));
            end
            hold_prev = valid_out && !ready_in;
            held      = {ovf_out, carry_out, result};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic got;
        int   idx;
        int   cyc;
        int   e0;
        int   n;
        logic exp_v;

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_0009, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[5] = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[6] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vecs[7] = '{32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
        vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

        // Reset state
        rst_n    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        num1     = 32'd0;
        num2     = 32'd0;
        carry_in = 1'b0;
        sub_in   = 1'b0;
        repeat (3) cycle();
        @(negedge clk);
        chk("reset_valid", 32'(valid_out), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_carry", 32'(carry_out), 32'd0);
        chk("reset_overflow", 32'(ovf_out), 32'd0);
        cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(ready_out), 32'd1);

        // Directed vectors, one at a time, with latency measurement
        for (int i = 0; i < 9; i++) begin
            cycle();
            num1     = vecs[i].a;
            num2     = vecs[i].b;
            carry_in = vecs[i].cin;
            sub_in   = vecs[i].sub;
            valid_in = 1'b1;
            ready_in = 1'b1;
            cycle();
            valid_in = 1'b0;
            lat      = 0;
            got      = 1'b0;
            while (lat < 20 && !got) begin
                @(negedge clk);
                lat++;
                got = valid_out;
            end
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(STAGES));
            chk($sformatf("vec%0d_result", i), result, vecs[i].res);
            chk($sformatf("vec%0d_carry", i), 32'(carry_out), 32'(vecs[i].cout));
            chk($sformatf("vec%0d_overflow", i), 32'(ovf_out), 32'(vecs[i].ovf));
            repeat (2) cycle();
        end

        // Streaming 8 ops with a 3-cycle backpressure window
        idx = 0;
        cyc = 0;
        e0  = emitted;
        while ((idx < 8 || exp_q.size() != 0) && cyc < 100) begin
            ready_in = !(cyc >= 6 && cyc < 9);
            if (idx < 8) begin
                valid_in = 1'b1;
                num1     = 32'(idx);
                num2     = 32'(idx) * 32'h0101_0101;
                carry_in = 1'b0;
                sub_in   = 1'b0;
            end else begin
                valid_in = 1'b0;
            end
            @(negedge clk);
            if (!ready_in && valid_out) begin
                chk("stream_ready_low", 32'(ready_out), 32'd0);
            end
            if (valid_in && ready_out) begin
                idx++;
            end
            cycle();
            cyc++;
        end
        chk("stream_count", 32'(emitted - e0), 32'd8);
        valid_in = 1'b0;
        ready_in = 1'b1;

        // Bubbles: alternating valid pattern must reappear 4 cycles later
        repeat (3) cycle();
        for (int m = 0; m < 12; m++) begin
            valid_in = (m < 6) ? ((m % 2) == 0) : 1'b0;
            num1     = $urandom();
            num2     = $urandom();
            sub_in   = 1'($urandom_range(0, 1));
            carry_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_v = (m >= 4 && m < 10) ? (((m - 4) % 2) == 0) : 1'b0;
            chk($sformatf("bubble_valid_%0d", m), 32'(valid_out), 32'(exp_v));
            cycle();
        end

        // Reset mid-operation: three ops in flight are discarded
        for (int j = 0; j < 3; j++) begin
            valid_in = 1'b1;
            num1     = rand_opnd();
            num2     = rand_opnd();
            sub_in   = 1'($urandom_range(0, 1));
            carry_in = 1'($urandom_range(0, 1));
            cycle();
        end
        valid_in = 1'b0;
        rst_n    = 1'b0;
        cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(valid_out), 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_carry", 32'(carry_out), 32'd0);
        chk("midrst_overflow", 32'(ovf_out), 32'd0);
        chk("midrst_ready", 32'(ready_out), 32'd1);
        for (int j = 0; j < 8; j++) begin
            cycle();
            @(negedge clk);
            chk("midrst_no_stale", 32'(valid_out), 32'd0);
        end

        // Randomized traffic with random backpressure
        cycle();
        for (int r = 0; r < 300; r++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            ready_in = ($urandom_range(0, 9) < 7);
            num1     = rand_opnd();
            num2     = rand_opnd();
            carry_in = 1'($urandom_range(0, 1));
            sub_in   = 1'($urandom_range(0, 1));
            cycle();
        end

        // Drain
        valid_in = 1'b0;
        ready_in = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            cycle();
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
